// File: rtl/data_memory_pkg.sv
// Shared constants and word/address types for the data memory and the MBR that drives it.
package data_memory_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   typedef logic [DATA_W_DEF-1:0] mem_word_t;
   typedef logic [ADDR_W_DEF-1:0] mem_addr_t;

endpackage

// File: rtl/data_memory.sv
// Single-port synchronous RAM with read-first collision behaviour and registered read.
// Define DATA_MEMORY_OUT_REG_EN to add an output pipeline register (read latency 2).
module data_memory
   import data_memory_pkg::*;
#(
   parameter int                 DATA_W    = DATA_W_DEF,
   parameter int                 ADDR_W    = ADDR_W_DEF,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic              clka,
   input  logic              rsta_n,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdData;

   // The read register samples the array before this edge's write lands, giving read-first.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_VAL;
         end
         r_rdData <= RESET_VAL;
      end else begin
         if (wea) begin
            r_mem[addra] <= dina;
         end
         r_rdData <= r_mem[addra];
      end
   end

`ifdef DATA_MEMORY_OUT_REG_EN
   logic [DATA_W-1:0] r_outData;

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         r_outData <= RESET_VAL;
      end else begin
         r_outData <= r_rdData;
      end
   end

   assign douta = r_outData;
`else
   assign douta = r_rdData;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: driver pushes expected read data, monitor pops and compares.
module tb_data_memory;

`ifdef DATA_MEMORY_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int unsigned edgeIdx;
      logic [7:0]  expData;
      string       tag;
   } sbEntry_t;

   logic       clka;
   logic       rsta_n;
   logic       wea;
   logic [3:0] addra;
   logic [7:0] dina;
   logic [7:0] douta;
   logic       clkEn;

   logic [7:0]  refMem [16];
   sbEntry_t    sbQ [$];
   sbEntry_t    popped;
   int unsigned edgeCount;
   int          checks;
   int          errors;

   data_memory dut (
      .clka   (clka),
      .rsta_n (rsta_n),
      .wea    (wea),
      .addra  (addra),
      .dina   (dina),
      .douta  (douta)
   );

   initial begin
      clka = 1'b0;
      forever begin
         #5;
         if (clkEn) clka = ~clka;
      end
   end

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: douta=%h expected=%h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One access per cycle; the expected read value is the array content before this write.
   task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [7:0] data, input string tag);
      sbEntry_t ent;
      @(negedge clka);
      wea   = we;
      addra = addr;
      dina  = data;
      ent.edgeIdx = edgeCount + 1;
      ent.expData = refMem[addr];
      ent.tag     = tag;
      sbQ.push_back(ent);
      if (we) refMem[addr] = data;
   endtask

   task automatic clearModel();
      for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
      sbQ.delete();
   endtask

   always @(posedge clka) begin
      edgeCount++;
      #1;
      while (sbQ.size() != 0 && sbQ[0].edgeIdx + LAT - 1 <= edgeCount) begin
         popped = sbQ.pop_front();
         checkOutput(popped.tag, douta, popped.expData);
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      edgeCount = 0;
      clkEn     = 1'b0;
      rsta_n    = 1'b1;
      wea       = 1'b0;
      addra     = 4'h0;
      dina      = 8'h00;
      clearModel();

      #2 rsta_n = 1'b0;
      #1 checkOutput("resetAsync", douta, 8'h00);
      #5 clkEn = 1'b1;
      @(negedge clka);
      rsta_n = 1'b1;

      for (int a = 0; a < 16; a++) applyStimulus(1'b0, 4'(a), 8'h00, "resetRead");

      applyStimulus(1'b1, 4'd0, 8'h80, "writeA0");
      applyStimulus(1'b0, 4'd0, 8'h00, "readA0");
      applyStimulus(1'b0, 4'd1, 8'h00, "isolationA1");
      applyStimulus(1'b0, 4'd0, 8'h00, "readA0Again");

      applyStimulus(1'b1, 4'd5, 8'h11, "preloadA5");
      applyStimulus(1'b1, 4'd5, 8'h22, "collisionA5");
      applyStimulus(1'b0, 4'd5, 8'h00, "afterCollisionA5");

      for (int a = 0; a < 16; a++) applyStimulus(1'b1, 4'(a), 8'(a) ^ 8'hA5, "fullRangeWrite");
      for (int a = 0; a < 16; a++) applyStimulus(1'b0, 4'(a), 8'h00, "fullRangeRead");

      applyStimulus(1'b1, 4'd7, 8'h3C, "writeA7");
      applyStimulus(1'b0, 4'd7, 8'h00, "readA7");
      applyStimulus(1'b0, 4'd0, 8'h00, "idleBeforeReset");

      // Reset asserted together with a write to address 8; both writes must be lost.
      @(negedge clka);
      wea    = 1'b1;
      addra  = 4'd8;
      dina   = 8'h5A;
      rsta_n = 1'b0;
      clearModel();
      #1 checkOutput("midResetAsync", douta, 8'h00);
      for (int k = 0; k < 2; k++) begin
         @(posedge clka);
         #2 checkOutput("resetHold", douta, 8'h00);
      end
      @(negedge clka);
      wea    = 1'b0;
      rsta_n = 1'b1;
      applyStimulus(1'b0, 4'd7, 8'h00, "postResetA7");
      applyStimulus(1'b0, 4'd8, 8'h00, "postResetA8");

      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       8'($urandom_range(0, 255)), "random");
      end
      applyStimulus(1'b0, 4'd15, 8'h00, "finalRead");
      @(negedge clka);
      wea = 1'b0;

      for (int i = 0; i < 10 && sbQ.size() != 0; i++) @(posedge clka);
      #3;
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: pending=%0d expected=0", sbQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
